// File: rtl/cpu_pkg.sv
// Shared CPU definitions: fetch address width, instruction field widths,
// the HALT opcode and the fetch-stage state encoding.
package cpu_pkg;

    // Program counter / instruction-memory address width.
    localparam int PC_W = 8;

    // Instruction field widths.
    localparam int OPCODE_W = 5;
    localparam int DESTIN_W = 4;
    localparam int SOURCE_W = 4;
    localparam int IMM_W    = 9;

    // Opcode that stops instruction fetch until resume.
    localparam logic [OPCODE_W-1:0] HALT_OPCODE = 5'b11111;

    // Width of the saturating fetch counter.
    localparam int CNT_W = 16;

    // Fetch-stage control states.
    typedef enum logic [1:0] {
        START = 2'd0,
        FETCH = 2'd1,
        HALT  = 2'd2
    } fetch_state_e;

endpackage : cpu_pkg

// File: rtl/fetch_sequencer_if.sv
// Fetch-stage bus: control inputs from decode/execute, the opcode returned by
// the registered instruction memory, and the fetch address/status outputs.
interface fetch_sequencer_if #(
    parameter int PC_W  = cpu_pkg::PC_W,
    parameter int CNT_W = cpu_pkg::CNT_W
);

    // Requests into the fetch stage.
    logic                         stall;
    logic                         branch_taken;
    logic [PC_W-1:0]              branch_target;
    logic                         resume;
    logic [cpu_pkg::OPCODE_W-1:0] opcode;

    // Fetch address and status out of the fetch stage.
    logic [PC_W-1:0]              Address;
    logic                         instRead;
    logic                         inst_valid;
    logic [PC_W-1:0]              fetch_pc;
    logic                         halted;
    logic [CNT_W-1:0]             fetch_count;

    // The fetch sequencer side.
    modport master (
        input  stall, branch_taken, branch_target, resume, opcode,
        output Address, instRead, inst_valid, fetch_pc, halted, fetch_count
    );

    // The surrounding pipeline / instruction-memory side.
    modport slave (
        output stall, branch_taken, branch_target, resume, opcode,
        input  Address, instRead, inst_valid, fetch_pc, halted, fetch_count
    );

endinterface : fetch_sequencer_if

// File: rtl/fetch_sequencer.sv
// Program counter and fetch control in front of a registered instruction
// memory. Tracks which PC sits in the memory's output register, squashes on
// branch redirect, stops on HALT until resume, and counts fetches.
module fetch_sequencer #(
    parameter int                              PC_W        = cpu_pkg::PC_W,
    parameter logic [PC_W-1:0]                 RESET_PC    = '0,
    parameter logic [cpu_pkg::OPCODE_W-1:0]    HALT_OPCODE = cpu_pkg::HALT_OPCODE,
    parameter int                              CNT_W       = cpu_pkg::CNT_W
) (
    input  logic              clk,
    input  logic              Reset,
    fetch_sequencer_if.master bus
);

    import cpu_pkg::*;

    fetch_state_e     r_state;
    logic [PC_W-1:0]  r_pc;
    logic             r_inst_valid;
    logic [PC_W-1:0]  r_fetch_pc;
    logic             r_halted;
    logic [CNT_W-1:0] r_fetch_count;

    logic             w_halt_seen;
    logic             w_inst_read;

    // HALT detection and memory-load enable, both decided in the same cycle
    // the opcode is presented so a HALT never triggers a wasted fetch.
    always_comb begin
        // NOTE: every signal driven here gets a value on every path, otherwise a latch is inferred.
        w_halt_seen = 1'b0;
        w_inst_read = 1'b0;
        if (r_state == FETCH) begin
            w_halt_seen = r_inst_valid && (bus.opcode == HALT_OPCODE) && !bus.stall;
            w_inst_read = !bus.stall && !bus.branch_taken && !w_halt_seen;
        end
    end

    // Fetch FSM: pc, valid tracking and HALT handling. Redirect beats HALT
    // beats stall; a plain fetch advances pc and records the fetched PC.
    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) begin
            r_state      <= START;
            r_pc         <= RESET_PC;
            r_inst_valid <= 1'b0;
            r_fetch_pc   <= '0;
            r_halted     <= 1'b0;
        end else begin
            // NOTE: state registers use non-blocking assignment so every read in this block sees the pre-edge value.
            case (r_state)
                START: begin
                    r_state <= FETCH;
                end
                FETCH: begin
                    if (bus.branch_taken) begin
                        r_pc         <= bus.branch_target;
                        r_inst_valid <= 1'b0;
                    end else if (w_halt_seen) begin
                        r_state      <= HALT;
                        r_halted     <= 1'b1;
                        r_inst_valid <= 1'b0;
                    end else if (!bus.stall) begin
                        r_fetch_pc   <= r_pc;
                        r_inst_valid <= 1'b1;
                        r_pc         <= r_pc + 1'b1;
                    end
                end
                HALT: begin
                    // Branches and stalls are dropped here; only resume matters.
                    if (bus.resume) begin
                        r_state  <= FETCH;
                        r_halted <= 1'b0;
                    end
                end
                default: begin
                    r_state  <= START;
                    r_halted <= 1'b0;
                end
            endcase
        end
    end

    // Saturating count of cycles in which the instruction memory was loaded.
    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) begin
            r_fetch_count <= '0;
        end else if (w_inst_read && (r_fetch_count != {CNT_W{1'b1}})) begin
            r_fetch_count <= r_fetch_count + 1'b1;
        end
    end

    assign bus.Address     = r_pc;
    assign bus.instRead    = w_inst_read;
    assign bus.inst_valid  = r_inst_valid;
    assign bus.fetch_pc    = r_fetch_pc;
    assign bus.halted      = r_halted;
    assign bus.fetch_count = r_fetch_count;

endmodule : fetch_sequencer

// File: tb/tb_fetch_sequencer.sv
// Self-checking bench for fetch_sequencer: directed scenarios with literal
// expectations, a randomized phase, and a long run to counter saturation.
// A behavioural model of the fetch stage and of the instruction memory's
// output register supplies every expected value.
module tb_fetch_sequencer;

    localparam logic [4:0] HALT_OP = 5'b11111;
    localparam int         CNT_MAX = 65535;

    logic clk;
    logic Reset;

    fetch_sequencer_if #(.PC_W(8), .CNT_W(16)) bus ();

    fetch_sequencer dut (
        .clk   (clk),
        .Reset (Reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Behavioural model. m_mode: 0 = idle cycle after reset, 1 = fetching,
    // 2 = halted. m_opcode models the instruction memory's output register.
    logic [4:0] imem [256];
    logic [7:0] m_pc;
    int         m_mode;
    logic       m_valid;
    logic [7:0] m_fpc;
    int         m_count;
    logic [4:0] m_opcode;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_pc    = 8'h00;
        m_mode  = 0;
        m_valid = 1'b0;
        m_fpc   = 8'h00;
        m_count = 0;
    endtask

    // One clock: compare all outputs at the falling edge against the model,
    // then advance the model across the rising edge.
    task automatic step();
        logic       hs, rd;
        logic [7:0] n_pc, n_fpc;
        logic       n_valid;
        int         n_mode, n_count;
        logic [4:0] n_op;
        @(negedge clk);
        hs = (m_mode == 1) && m_valid && (bus.opcode == HALT_OP) && !bus.stall;
        rd = (m_mode == 1) && !bus.stall && !bus.branch_taken && !hs;
        check("Address",     bus.Address,     m_pc);
        check("instRead",    bus.instRead,    rd);
        check("inst_valid",  bus.inst_valid,  m_valid);
        check("fetch_pc",    bus.fetch_pc,    m_fpc);
        check("halted",      bus.halted,      (m_mode == 2));
        check("fetch_count", bus.fetch_count, m_count);
        n_pc = m_pc; n_fpc = m_fpc; n_valid = m_valid; n_mode = m_mode; n_count = m_count;
        if (m_mode == 0) begin
            n_mode = 1;
        end else if (m_mode == 1) begin
            if (bus.branch_taken) begin
                n_pc = bus.branch_target;
                n_valid = 1'b0;
            end else if (hs) begin
                n_mode = 2;
                n_valid = 1'b0;
            end else if (!bus.stall) begin
                n_fpc = m_pc;
                n_valid = 1'b1;
                n_pc = m_pc + 8'd1;
            end
        end else if (bus.resume) begin
            n_mode = 1;
        end
        if (rd && n_count < CNT_MAX) n_count++;
        n_op = rd ? imem[m_pc] : m_opcode;
        @(posedge clk);
        #1;
        m_pc = n_pc; m_fpc = n_fpc; m_valid = n_valid; m_mode = n_mode;
        m_count = n_count; m_opcode = n_op;
        bus.opcode = m_opcode;
    endtask

    // Assert Reset between clock edges and confirm outputs clear at once.
    task automatic async_reset();
        #2;
        Reset = 1'b1;
        #1;
        check("rst_Address",     bus.Address,     8'h00);
        check("rst_instRead",    bus.instRead,    1'b0);
        check("rst_inst_valid",  bus.inst_valid,  1'b0);
        check("rst_fetch_pc",    bus.fetch_pc,    8'h00);
        check("rst_halted",      bus.halted,      1'b0);
        check("rst_fetch_count", bus.fetch_count, 16'h0000);
        model_reset();
        @(posedge clk);
        #1;
        Reset = 1'b0;
    endtask

    task automatic set_inputs(input logic st, input logic br, input logic [7:0] tgt, input logic rs);
        bus.stall         = st;
        bus.branch_taken  = br;
        bus.branch_target = tgt;
        bus.resume        = rs;
    endtask

    initial begin
        int sat_cycles;
        for (int i = 0; i < 256; i++) imem[i] = 5'd0;
        imem[7] = HALT_OP;
        m_opcode   = 5'd0;
        bus.opcode = 5'd0;
        set_inputs(1'b0, 1'b0, 8'h00, 1'b0);
        Reset = 1'b1;
        model_reset();

        // Reset state, then release: one idle cycle, then sequential fetch.
        @(posedge clk);
        @(posedge clk);
        #1;
        check("lit_reset_instRead", bus.instRead, 1'b0);
        check("lit_reset_count",    bus.fetch_count, 16'h0000);
        Reset = 1'b0;
        #1;
        check("lit_start_instRead", bus.instRead, 1'b0);
        step();
        #1;
        check("lit_first_fetch_rd", bus.instRead, 1'b1);
        for (int i = 0; i < 4; i++) step();
        #1;
        check("lit_addr_4",   bus.Address,  8'h04);
        check("lit_fpc_3",    bus.fetch_pc, 8'h03);

        // Stall for three cycles at Address 4.
        set_inputs(1'b1, 1'b0, 8'h00, 1'b0);
        #1;
        check("lit_stall_rd", bus.instRead, 1'b0);
        for (int i = 0; i < 3; i++) step();
        #1;
        check("lit_stall_addr",  bus.Address,     8'h04);
        check("lit_stall_count", bus.fetch_count, 16'd4);
        check("lit_stall_valid", bus.inst_valid,  1'b1);
        set_inputs(1'b0, 1'b0, 8'h00, 1'b0);
        step();
        #1;
        check("lit_count_5", bus.fetch_count, 16'd5);
        check("lit_fpc_4",   bus.fetch_pc,    8'h04);

        // Redirect during a stall.
        set_inputs(1'b1, 1'b1, 8'h40, 1'b0);
        step();
        set_inputs(1'b0, 1'b0, 8'h00, 1'b0);
        #1;
        check("lit_br_addr",  bus.Address,    8'h40);
        check("lit_br_valid", bus.inst_valid, 1'b0);
        step();
        #1;
        check("lit_br_fpc",   bus.fetch_pc,   8'h40);
        check("lit_br_valid2", bus.inst_valid, 1'b1);

        // HALT at PC 7, ignored branch, resume at 8.
        set_inputs(1'b0, 1'b1, 8'h07, 1'b0);
        step();
        set_inputs(1'b0, 1'b0, 8'h00, 1'b0);
        step();
        #1;
        check("lit_halt_fpc", bus.fetch_pc, 8'h07);
        check("lit_halt_rd",  bus.instRead, 1'b0);
        step();
        #1;
        check("lit_halted",      bus.halted,     1'b1);
        check("lit_halt_valid",  bus.inst_valid, 1'b0);
        check("lit_halt_addr",   bus.Address,    8'h08);
        set_inputs(1'b1, 1'b1, 8'h55, 1'b0);
        step();
        #1;
        check("lit_halt_br_addr", bus.Address, 8'h08);
        set_inputs(1'b0, 1'b1, 8'h66, 1'b1);
        step();
        set_inputs(1'b0, 1'b0, 8'h00, 1'b0);
        #1;
        check("lit_resume_halted", bus.halted,  1'b0);
        check("lit_resume_addr",   bus.Address, 8'h08);
        step();
        #1;
        check("lit_resume_fpc", bus.fetch_pc, 8'h08);

        // PC wrap from FF to 00.
        set_inputs(1'b0, 1'b1, 8'hFE, 1'b0);
        step();
        set_inputs(1'b0, 1'b0, 8'h00, 1'b0);
        step();
        step();
        #1;
        check("lit_wrap_addr", bus.Address,  8'h00);
        check("lit_wrap_fpc",  bus.fetch_pc, 8'hFF);

        // Asynchronous reset mid-stall, then START followed by fetch at 0.
        set_inputs(1'b1, 1'b0, 8'h00, 1'b0);
        step();
        async_reset();
        set_inputs(1'b0, 1'b0, 8'h00, 1'b0);
        step();
        #1;
        check("lit_post_rst_addr", bus.Address,  8'h00);
        check("lit_post_rst_rd",   bus.instRead, 1'b1);

        // Asynchronous reset mid-HALT.
        set_inputs(1'b0, 1'b1, 8'h07, 1'b0);
        step();
        set_inputs(1'b0, 1'b0, 8'h00, 1'b0);
        step();
        step();
        #1;
        check("lit_halt2", bus.halted, 1'b1);
        async_reset();
        step();
        step();

        // Randomized traffic over a random program with scattered HALTs.
        for (int i = 0; i < 256; i++)
            imem[i] = ($urandom_range(0, 11) == 0) ? HALT_OP : 5'($urandom_range(0, 30));
        for (int i = 0; i < 3000; i++) begin
            set_inputs(($urandom_range(0, 3) == 0), ($urandom_range(0, 9) == 0),
                       8'($urandom), ($urandom_range(0, 2) == 0));
            if ($urandom_range(0, 499) == 0) async_reset();
            step();
        end

        // Free-running fetch until the counter has sat at its maximum a while.
        for (int i = 0; i < 256; i++) imem[i] = 5'd0;
        set_inputs(1'b0, 1'b0, 8'h00, 1'b1);
        sat_cycles = 0;
        for (int i = 0; i < 70000 && sat_cycles < 4; i++) begin
            step();
            if (m_count == CNT_MAX) sat_cycles++;
        end
        check("sat_reached", (sat_cycles >= 4), 1'b1);
        #1;
        check("lit_sat_count", bus.fetch_count, 16'hFFFF);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule : tb_fetch_sequencer
